// File: rtl/gen_mc_queue_with_spmem.sv
// Multi-channel FIFO: CH_NUM logical queues sharing one single-port memory with a
// registered read port. Sticky error flags are built only when GEN_MCQ_ERR_FLAGS_EN is defined.
module gen_mc_queue_with_spmem #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int CH_NUM  = 4,
  parameter int SIM_DLY = 1,
  localparam int DEPTH_W = $clog2(DEPTH + 1),
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sw_rst,
  input  logic [DEPTH_W-1:0]        cnfg_depth,
  input  logic [DEPTH_W-1:0]        cnfg_afull_th,
  input  logic                      push,
  input  logic                      pop,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic [DATA_W-1:0]         i_data,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_data_valid,
  output logic [CH_W-1:0]           o_ch,
  output logic [CH_NUM-1:0]         full,
  output logic [CH_NUM-1:0]         empty,
  output logic [CH_NUM-1:0]         afull,
  output logic [CH_NUM*DEPTH_W-1:0] fullness,
  output logic                      err_ovf,
  output logic                      err_udf,
  output logic                      err_coll
);

  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_WORDS = CH_NUM * DEPTH;
  localparam int ADDR_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_ERR} op_t;

  op_t                     op_reg, op_next;
  logic [CH_W-1:0]         o_ch_reg;
  logic [CH_NUM*PTR_W-1:0] head_all, tail_all;
  logic [PTR_W-1:0]        sel_head, sel_tail, head_next, tail_next;
  logic [DEPTH_W-1:0]      sel_cnt, cnt_next, depth_eff;
  logic                    full_next, empty_next, afull_next;
  logic                    mem_we, mem_re;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       rd_data_reg;

  // Out-of-range depth settings fall back to the full per-channel region.
  assign depth_eff = ((cnfg_depth != '0) && (cnfg_depth <= DEPTH_W'(DEPTH))) ?
                     cnfg_depth : DEPTH_W'(DEPTH);

  // ">=" also recovers a pointer left beyond a newly shrunk depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                input logic [DEPTH_W-1:0] d);
    return (DEPTH_W'(p) >= d - DEPTH_W'(1)) ? '0 : p + 1'b1;
  endfunction

  assign sel_head = head_all[ch_sel*PTR_W +: PTR_W];
  assign sel_tail = tail_all[ch_sel*PTR_W +: PTR_W];
  assign sel_cnt  = fullness[ch_sel*DEPTH_W +: DEPTH_W];

  always_comb begin
    op_next   = OP_IDLE;
    head_next = sel_head;
    tail_next = sel_tail;
    cnt_next  = sel_cnt;
    if (push && pop)
      op_next = OP_ERR;
    else if (push)
      op_next = full[ch_sel] ? OP_ERR : OP_PUSH;
    else if (pop)
      op_next = empty[ch_sel] ? OP_ERR : OP_POP;

    if (op_next == OP_PUSH) begin
      tail_next = ptr_inc(sel_tail, depth_eff);
      cnt_next  = sel_cnt + 1'b1;
    end else if (op_next == OP_POP) begin
      head_next = ptr_inc(sel_head, depth_eff);
      cnt_next  = sel_cnt - 1'b1;
    end
    full_next  = (cnt_next >= depth_eff);
    empty_next = (cnt_next == '0);
    afull_next = (cnt_next >= cnfg_afull_th) && (cnfg_afull_th != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_reg   <= OP_IDLE;
      o_ch_reg <= '0;
    end else if (sw_rst) begin
      op_reg   <= OP_IDLE;
      o_ch_reg <= '0;
    end else begin
      op_reg <= op_next;
      if (op_next == OP_POP)
        o_ch_reg <= ch_sel;
    end
  end

  assign o_data_valid = (op_reg == OP_POP);
  assign o_ch         = o_ch_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [PTR_W-1:0]   head_reg, tail_reg;
      logic [DEPTH_W-1:0] cnt_reg;
      logic               full_reg, empty_reg, afull_reg;
      logic               hit;

      assign hit = (ch_sel == CH_W'(gi)) && ((op_next == OP_PUSH) || (op_next == OP_POP));

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          cnt_reg   <= '0;
          full_reg  <= 1'b0;
          empty_reg <= 1'b1;
          afull_reg <= 1'b0;
        end else if (sw_rst) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          cnt_reg   <= '0;
          full_reg  <= 1'b0;
          empty_reg <= 1'b1;
          afull_reg <= 1'b0;
        end else if (hit) begin
          head_reg  <= head_next;
          tail_reg  <= tail_next;
          cnt_reg   <= cnt_next;
          full_reg  <= full_next;
          empty_reg <= empty_next;
          afull_reg <= afull_next;
        end
      end

      assign head_all[gi*PTR_W +: PTR_W]     = head_reg;
      assign tail_all[gi*PTR_W +: PTR_W]     = tail_reg;
      assign fullness[gi*DEPTH_W +: DEPTH_W] = cnt_reg;
      assign full[gi]  = full_reg;
      assign empty[gi] = empty_reg;
      assign afull[gi] = afull_reg;
    end
  endgenerate

  assign mem_we   = (op_next == OP_PUSH) && rstn && !sw_rst;
  assign mem_re   = (op_next == OP_POP) && rstn && !sw_rst;
  assign mem_addr = ADDR_W'(ch_sel) * ADDR_W'(DEPTH) +
                    ADDR_W'((op_next == OP_PUSH) ? sel_tail : sel_head);

  // SIM_DLY only shapes timing of behavioural memory models; this array is zero-delay.
  generate
    if (SIM_DLY >= 0) begin : g_mem
      logic [DATA_W-1:0] mem [MEM_WORDS];
      always_ff @(posedge clk) begin
        if (mem_we)
          mem[mem_addr] <= i_data;
        else if (mem_re)
          rd_data_reg <= mem[mem_addr];
      end
    end else begin : g_mem_none
      assign rd_data_reg = '0;
    end
  endgenerate

  assign o_data = rd_data_reg;

`ifdef GEN_MCQ_ERR_FLAGS_EN
  logic err_ovf_reg, err_udf_reg, err_coll_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf_reg  <= 1'b0;
      err_udf_reg  <= 1'b0;
      err_coll_reg <= 1'b0;
    end else if (sw_rst) begin
      err_ovf_reg  <= 1'b0;
      err_udf_reg  <= 1'b0;
      err_coll_reg <= 1'b0;
    end else begin
      if (push && pop)                     err_coll_reg <= 1'b1;
      if (push && !pop && full[ch_sel])    err_ovf_reg  <= 1'b1;
      if (pop && !push && empty[ch_sel])   err_udf_reg  <= 1'b1;
    end
  end

  assign err_ovf  = err_ovf_reg;
  assign err_udf  = err_udf_reg;
  assign err_coll = err_coll_reg;
`else
  assign err_ovf  = 1'b0;
  assign err_udf  = 1'b0;
  assign err_coll = 1'b0;
`endif

endmodule

// File: tb/tb_gen_mc_queue_with_spmem.sv
// Bench for gen_mc_queue_with_spmem: directed scenarios plus random traffic, all checked
// against per-channel software queues.
module tb_gen_mc_queue_with_spmem;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int CH_NUM  = 4;
  localparam int DEPTH_W = 5;
  localparam int CH_W    = 2;
`ifdef GEN_MCQ_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0, sw_rst = 1'b0, push = 1'b0, pop = 1'b0;
  logic [DEPTH_W-1:0] cnfg_depth = '0, cnfg_afull_th = '0;
  logic [CH_W-1:0] ch_sel = '0;
  logic [DATA_W-1:0] i_data = '0;
  logic [DATA_W-1:0] o_data;
  logic o_data_valid;
  logic [CH_W-1:0] o_ch;
  logic [CH_NUM-1:0] full, empty, afull;
  logic [CH_NUM*DEPTH_W-1:0] fullness;
  logic err_ovf, err_udf, err_coll;

  gen_mc_queue_with_spmem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH_NUM(CH_NUM), .SIM_DLY(1)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .cnfg_depth(cnfg_depth),
    .cnfg_afull_th(cnfg_afull_th), .push(push), .pop(pop), .ch_sel(ch_sel),
    .i_data(i_data), .o_data(o_data), .o_data_valid(o_data_valid), .o_ch(o_ch),
    .full(full), .empty(empty), .afull(afull), .fullness(fullness),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_coll(err_coll)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus expected output registers.
  logic [DATA_W-1:0] mq [CH_NUM][$];
  bit m_ovf, m_udf, m_coll, m_valid;
  logic [CH_W-1:0] m_och;
  logic [DATA_W-1:0] m_data;

  function automatic int eff_depth();
    if (cnfg_depth >= 1 && int'(cnfg_depth) <= DEPTH) return int'(cnfg_depth);
    return DEPTH;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < CH_NUM; k++) mq[k].delete();
    m_ovf = 0; m_udf = 0; m_coll = 0; m_valid = 0; m_och = '0;
  endfunction

  function automatic int dut_cnt(input int k);
    return int'(fullness[k*DEPTH_W +: DEPTH_W]);
  endfunction

  task automatic step(input bit p, input bit q, input int ch, input logic [DATA_W-1:0] d);
    push = p; pop = q; ch_sel = ch[CH_W-1:0]; i_data = d;
    @(posedge clk);
    m_valid = 0;
    if (p && q) m_coll = 1;
    else if (p) begin
      if (mq[ch].size() >= eff_depth()) m_ovf = 1;
      else mq[ch].push_back(d);
    end else if (q) begin
      if (mq[ch].size() == 0) m_udf = 1;
      else begin
        m_data = mq[ch].pop_front(); m_valid = 1; m_och = ch[CH_W-1:0];
      end
    end
    @(negedge clk);
    push = 0; pop = 0;
    $display("txn push=%0b pop=%0b ch=%0d din=%02h | valid=%0b dout=%02h och=%0d full=%b empty=%b afull=%b fullness=%h err=%0b%0b%0b",
             p, q, ch, d, o_data_valid, o_data, o_ch, full, empty, afull, fullness, err_ovf, err_udf, err_coll);
  endtask

  task automatic soft_reset(input bit with_pop, input int ch);
    sw_rst = 1; pop = with_pop; ch_sel = ch[CH_W-1:0];
    @(posedge clk);
    model_reset();
    @(negedge clk);
    sw_rst = 0; pop = 0;
    $display("txn sw_rst pop=%0b ch=%0d | valid=%0b empty=%b fullness=%h", with_pop, ch, o_data_valid, empty, fullness);
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (3) @(negedge clk);
    rstn = 1;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
    checks++; if (empty !== 4'b1111) begin errors++; $display("FAIL reset_empty got %b want 1111", empty); end
    checks++; if (full !== 4'b0000) begin errors++; $display("FAIL reset_full got %b want 0000", full); end
    checks++; if (afull !== 4'b0000) begin errors++; $display("FAIL reset_afull got %b want 0000", afull); end
    checks++; if (fullness !== '0) begin errors++; $display("FAIL reset_fullness got %h want 0", fullness); end
    checks++; if (o_data_valid !== 1'b0 || o_ch !== '0) begin errors++; $display("FAIL reset_valid got v=%b ch=%0d want 0/0", o_data_valid, o_ch); end
    checks++; if ({err_ovf, err_udf, err_coll} !== 3'b000) begin errors++; $display("FAIL reset_err got %b want 000", {err_ovf, err_udf, err_coll}); end
  endtask

  task automatic test_fill_drain();
    logic [DATA_W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    cnfg_depth = 4; cnfg_afull_th = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 2, vals[i]);
      checks++; if (dut_cnt(2) !== i + 1) begin errors++; $display("FAIL fill_cnt got %0d want %0d", dut_cnt(2), i + 1); end
      checks++; if (full[2] !== (i == 3)) begin errors++; $display("FAIL fill_full got %b want %b", full[2], i == 3); end
    end
    step(1, 0, 2, 8'h55);
    checks++; if (dut_cnt(2) !== 4) begin errors++; $display("FAIL ovf_cnt got %0d want 4", dut_cnt(2)); end
    checks++; if (err_ovf !== ERR_EN) begin errors++; $display("FAIL ovf_flag got %b want %b", err_ovf, ERR_EN); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2, 8'h00);
      checks++;
      if (o_data_valid !== 1'b1 || o_data !== vals[i] || o_ch !== 2'd2) begin
        errors++; $display("FAIL drain_data got v=%b d=%02h ch=%0d want 1/%02h/2", o_data_valid, o_data, o_ch, vals[i]);
      end
    end
    checks++; if (empty[2] !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty[2]); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_q [$];
    int ops [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
    logic [DATA_W-1:0] pv [4] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
    int pi = 0;
    cnfg_depth = 3;
    for (int i = 0; i < 8; i++) begin
      if (ops[i] == 1) begin step(1, 0, 1, pv[pi]); exp_q.push_back(pv[pi]); pi++; end
      else begin step(0, 1, 1, 8'h00); if (o_data_valid) got_q.push_back(o_data); end
    end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (dut_cnt(1) !== 0 || empty[1] !== 1'b1) begin errors++; $display("FAIL wrap_final got cnt=%0d empty=%b want 0/1", dut_cnt(1), empty[1]); end
  endtask

  task automatic test_isolation();
    cnfg_depth = 4;
    step(1, 0, 0, 8'hAA);
    step(1, 0, 3, 8'hBB);
    checks++; if (dut_cnt(1) !== 0 || dut_cnt(2) !== 0) begin errors++; $display("FAIL iso_other got c1=%0d c2=%0d want 0/0", dut_cnt(1), dut_cnt(2)); end
    step(0, 1, 3, 8'h00);
    checks++; if (o_data_valid !== 1'b1 || o_data !== 8'hBB || o_ch !== 2'd3) begin errors++; $display("FAIL iso_ch3 got v=%b d=%02h ch=%0d want 1/bb/3", o_data_valid, o_data, o_ch); end
    checks++; if (dut_cnt(0) !== 1) begin errors++; $display("FAIL iso_ch0_cnt got %0d want 1", dut_cnt(0)); end
    step(0, 1, 0, 8'h00);
    checks++; if (o_data_valid !== 1'b1 || o_data !== 8'hAA || o_ch !== 2'd0) begin errors++; $display("FAIL iso_ch0 got v=%b d=%02h ch=%0d want 1/aa/0", o_data_valid, o_data, o_ch); end
  endtask

  task automatic test_illegal();
    step(0, 1, 1, 8'h00);
    checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL udf_valid got %b want 0", o_data_valid); end
    checks++; if (err_udf !== ERR_EN) begin errors++; $display("FAIL udf_flag got %b want %b", err_udf, ERR_EN); end
    step(1, 0, 0, 8'h5A);
    step(1, 1, 0, 8'h66);
    checks++; if (dut_cnt(0) !== 1 || o_data_valid !== 1'b0) begin errors++; $display("FAIL coll_state got cnt=%0d v=%b want 1/0", dut_cnt(0), o_data_valid); end
    checks++; if (err_coll !== ERR_EN) begin errors++; $display("FAIL coll_flag got %b want %b", err_coll, ERR_EN); end
    step(0, 1, 0, 8'h00);
    checks++; if (o_data !== 8'h5A) begin errors++; $display("FAIL coll_data got %02h want 5a", o_data); end
  endtask

  task automatic test_afull_swrst();
    cnfg_depth = 4; cnfg_afull_th = 3;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'($urandom));
      checks++; if (afull[0] !== (i == 2)) begin errors++; $display("FAIL afull_rise got %b want %b", afull[0], i == 2); end
    end
    step(0, 1, 0, 8'h00);
    checks++; if (afull[0] !== 1'b0) begin errors++; $display("FAIL afull_fall got %b want 0", afull[0]); end
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    soft_reset(1, 0);
    checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL swrst_valid got %b want 0", o_data_valid); end
    checks++;
    if (empty !== 4'b1111 || full !== 4'b0 || afull !== 4'b0 || fullness !== '0 || o_ch !== '0 ||
        {err_ovf, err_udf, err_coll} !== 3'b000) begin
      errors++; $display("FAIL swrst_state got e=%b f=%b af=%b n=%h ch=%0d err=%b%b%b want reset values",
                         empty, full, afull, fullness, o_ch, err_ovf, err_udf, err_coll);
    end
  endtask

  task automatic test_random();
    logic [CH_NUM-1:0] ef, ee, ea;
    int r, ch, d;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      ch = $urandom_range(0, CH_NUM - 1);
      if (r < 3) begin
        soft_reset($urandom_range(0, 1) == 1, ch);
        cnfg_depth = DEPTH_W'($urandom_range(0, 20));
        cnfg_afull_th = DEPTH_W'($urandom_range(0, 18));
      end else if (r < 6) step(1, 1, ch, 8'($urandom));
      else if (r < 56) step(1, 0, ch, 8'($urandom));
      else step(0, 1, ch, 8'h00);
      d = eff_depth();
      for (int k = 0; k < CH_NUM; k++) begin
        ef[k] = (mq[k].size() >= d);
        ee[k] = (mq[k].size() == 0);
        ea[k] = (cnfg_afull_th != 0) && (mq[k].size() >= int'(cnfg_afull_th));
        checks++; if (dut_cnt(k) !== mq[k].size()) begin errors++; $display("FAIL rnd_fullness[%0d] got %0d want %0d", k, dut_cnt(k), mq[k].size()); end
      end
      checks++; if (full !== ef || empty !== ee || afull !== ea) begin errors++; $display("FAIL rnd_status got f=%b e=%b a=%b want f=%b e=%b a=%b", full, empty, afull, ef, ee, ea); end
      checks++; if (o_data_valid !== m_valid || o_ch !== m_och) begin errors++; $display("FAIL rnd_valid got v=%b ch=%0d want v=%b ch=%0d", o_data_valid, o_ch, m_valid, m_och); end
      if (m_valid) begin
        checks++; if (o_data !== m_data) begin errors++; $display("FAIL rnd_data got %02h want %02h", o_data, m_data); end
      end
      checks++;
      if ({err_ovf, err_udf, err_coll} !== ({m_ovf, m_udf, m_coll} & {3{ERR_EN}})) begin
        errors++; $display("FAIL rnd_err got %b want %b", {err_ovf, err_udf, err_coll}, {m_ovf, m_udf, m_coll} & {3{ERR_EN}});
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_isolation();
    test_illegal();
    test_afull_swrst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
